// File: rtl/axi_lite_regfile_slave.sv
// ============================================================================
// axi_lite_regfile_slave
//
// AXI4-Lite slave exposing NUM_REGS byte-strobed registers of DATA_WIDTH bits.
// Only one transaction is in flight at a time. A read wins over a write that
// arrives in the same cycle. Address and data of a write may arrive in either
// order; the first half is held until the second half arrives.
//
// Parameters
//   ADDR_WIDTH  byte-address width of AWADDR/ARADDR (default 12)
//   DATA_WIDTH  data width, 32 or 64 (default 32)
//   NUM_REGS    number of registers (default 16)
//
// Ports
//   ACLK, ARESETN              clock (rising edge), async active-low reset
//   AWADDR/AWVALID/AWREADY     write-address channel
//   WDATA/WSTRB/WVALID/WREADY  write-data channel
//   BRESP/BVALID/BREADY        write-response channel
//   ARADDR/ARVALID/ARREADY     read-address channel
//   RDATA/RRESP/RVALID/RREADY  read-data channel
//
// Configuration macro
//   AXI_LITE_ERR_RESP_EN  when defined, out-of-range accesses answer SLVERR;
//                         otherwise they answer OKAY (reads return 0, writes
//                         are dropped).
// ============================================================================
module axi_lite_regfile_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFFS       = $clog2(STRB_WIDTH);
    localparam int IDX_W      = ADDR_WIDTH - OFFS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RDATA,
        ST_WCAPT,
        ST_WRESP
    } state_t;

    state_t state_reg, state_next;

    // Goes high on the first clock edge after reset release; keeps all
    // readies low until then.
    logic run_reg;

    // In ST_WCAPT: 1 = address half captured, 0 = data half captured.
    logic                    have_aw_reg, have_aw_next;
    logic [ADDR_WIDTH-1:0]   aw_addr_reg, aw_addr_next;
    logic [DATA_WIDTH-1:0]   w_data_reg,  w_data_next;
    logic [STRB_WIDTH-1:0]   w_strb_reg,  w_strb_next;

    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic [1:0]              rresp_reg, rresp_next;
    logic [1:0]              bresp_reg, bresp_next;

    logic                    ar_hs, aw_hs, w_hs;

    logic                    wr_en;
    logic                    wr_commit;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [STRB_WIDTH-1:0]   wr_strb;
    logic [IDX_W-1:0]        wr_idx;
    logic                    wr_in_range;
    logic [1:0]              wr_resp;

    logic [IDX_W-1:0]        rd_idx;
    logic                    rd_in_range;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic [1:0]              rd_resp;

    logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat;

    // Byte-offset address bits carry no information for word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[OFFS-1:0], ARADDR[OFFS-1:0]};

    // ------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------
    always_comb begin
        ARREADY = 1'b0;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        if (run_reg) begin
            case (state_reg)
                ST_IDLE: begin
                    ARREADY = 1'b1;
                    // A pending read blocks the write channels this cycle.
                    AWREADY = !ARVALID;
                    WREADY  = !ARVALID;
                end
                ST_WCAPT: begin
                    AWREADY = !have_aw_reg;
                    WREADY  = have_aw_reg;
                end
                default: ;
            endcase
        end
    end

    assign ar_hs = ARVALID && ARREADY;
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;

    // ------------------------------------------------------------------
    // Write path: merge live and captured halves into one write request
    // ------------------------------------------------------------------
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = AWADDR;
        wr_data = WDATA;
        wr_strb = WSTRB;
        case (state_reg)
            ST_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_en = 1'b1;
                end
            end
            ST_WCAPT: begin
                if (have_aw_reg && w_hs) begin
                    wr_en   = 1'b1;
                    wr_addr = aw_addr_reg;
                end else if (!have_aw_reg && aw_hs) begin
                    wr_en   = 1'b1;
                    wr_data = w_data_reg;
                    wr_strb = w_strb_reg;
                end
            end
            default: ;
        endcase
    end

    assign wr_idx      = wr_addr[ADDR_WIDTH-1:OFFS];
    assign wr_in_range = (32'(wr_idx) < NUM_REGS);
    // Out-of-range writes never touch storage, whichever response is chosen.
    assign wr_commit   = wr_en && wr_in_range;

    assign rd_idx      = ARADDR[ADDR_WIDTH-1:OFFS];
    assign rd_in_range = (32'(rd_idx) < NUM_REGS);

`ifdef AXI_LITE_ERR_RESP_EN
    assign wr_resp = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    // ------------------------------------------------------------------
    // Register storage, one byte-strobed register per index
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
            logic [DATA_WIDTH-1:0] value_reg;
            logic                  hit;

            assign hit = wr_commit && (32'(wr_idx) == gi);

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    value_reg <= '0;
                end else if (hit) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (wr_strb[b]) begin
                            value_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
        end
    endgenerate

    // Read mux; an index with no matching register yields zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_idx) == i) begin
                rd_val = reg_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath capture
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        have_aw_next = have_aw_reg;
        aw_addr_next = aw_addr_reg;
        w_data_next  = w_data_reg;
        w_strb_next  = w_strb_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        bresp_next   = bresp_reg;

        case (state_reg)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_next = ST_RDATA;
                    rdata_next = rd_in_range ? rd_val : '0;
                    rresp_next = rd_resp;
                end else if (aw_hs && w_hs) begin
                    state_next = ST_WRESP;
                    bresp_next = wr_resp;
                end else if (aw_hs) begin
                    state_next   = ST_WCAPT;
                    have_aw_next = 1'b1;
                    aw_addr_next = AWADDR;
                end else if (w_hs) begin
                    state_next   = ST_WCAPT;
                    have_aw_next = 1'b0;
                    w_data_next  = WDATA;
                    w_strb_next  = WSTRB;
                end
            end
            ST_RDATA: begin
                if (RREADY) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WCAPT: begin
                if (wr_en) begin
                    state_next = ST_WRESP;
                    bresp_next = wr_resp;
                end
            end
            ST_WRESP: begin
                if (BREADY) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg   <= ST_IDLE;
            run_reg     <= 1'b0;
            have_aw_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
            bresp_reg   <= RESP_OKAY;
        end else begin
            state_reg   <= state_next;
            run_reg     <= 1'b1;
            have_aw_reg <= have_aw_next;
            aw_addr_reg <= aw_addr_next;
            w_data_reg  <= w_data_next;
            w_strb_reg  <= w_strb_next;
            rdata_reg   <= rdata_next;
            rresp_reg   <= rresp_next;
            bresp_reg   <= bresp_next;
        end
    end

    assign RVALID = (state_reg == ST_RDATA);
    assign BVALID = (state_reg == ST_WRESP);
    assign RDATA  = rdata_reg;
    assign RRESP  = rresp_reg;
    assign BRESP  = bresp_reg;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
module tb_axi_lite_regfile_slave;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;

`ifdef AXI_LITE_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;

    int checks = 0;
    int errors = 0;

    axi_lite_regfile_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (16)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit got     = 1'b0;
        bit aw_hs, w_hs;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin WVALID  = 1'b0; w_done  = 1'b1; end
        end
        check("wr_addr_data_accept", 64'(aw_done && w_done), 64'd1);
        resp = 2'bxx;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            if (BVALID) begin resp = BRESP; got = 1'b1; end
            @(posedge ACLK); #1;
        end
        BREADY = 1'b0;
        check("wr_bvalid_seen", 64'(got), 64'd1);
        $display("WR addr=%h data=%h strb=%h bresp=%b", a, d, s, resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
        bit ar_done = 1'b0;
        bit got     = 1'b0;
        bit ar_hs;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            @(negedge ACLK);
            ar_hs = ARVALID && ARREADY;
            @(posedge ACLK); #1;
            if (ar_hs) begin ARVALID = 1'b0; ar_done = 1'b1; end
        end
        check("rd_addr_accept", 64'(ar_done), 64'd1);
        d = 'x; resp = 2'bxx;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            if (RVALID) begin d = RDATA; resp = RRESP; got = 1'b1; end
            @(posedge ACLK); #1;
        end
        RREADY = 1'b0;
        check("rd_rvalid_seen", 64'(got), 64'd1);
        $display("RD addr=%h rdata=%h rresp=%b", a, d, resp);
    endtask

    initial begin
        logic [1:0]    resp;
        logic [DW-1:0] data;
        int            bcount;

        ARESETN = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset state
        #2 ARESETN = 1'b0;
        #1;
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_awready", 64'(AWREADY), 64'd0);
        check("rst_wready",  64'(WREADY),  64'd0);
        check("rst_rvalid",  64'(RVALID),  64'd0);
        check("rst_bvalid",  64'(BVALID),  64'd0);
        check("rst_rdata",   64'(RDATA),   64'd0);
        check("rst_rresp",   64'(RRESP),   64'd0);
        check("rst_bresp",   64'(BRESP),   64'd0);
        repeat (2) @(posedge ACLK);
        #1 check("rst_arready_held", 64'(ARREADY), 64'd0);
        @(negedge ACLK) ARESETN = 1'b1;
        #1 check("post_rst_arready_before_edge", 64'(ARREADY), 64'd0);
        @(posedge ACLK); #1;
        check("idle_arready", 64'(ARREADY), 64'd1);
        check("idle_awready", 64'(AWREADY), 64'd1);
        check("idle_wready",  64'(WREADY),  64'd1);

        // Full-word write then read back
        axi_write(12'h004, 32'hDEADBEEF, 4'hF, resp);
        check("wr004_bresp", 64'(resp), 64'd0);
        axi_read(12'h004, data, resp);
        check("rd004_rdata", 64'(data), 64'hDEADBEEF);
        check("rd004_rresp", 64'(resp), 64'd0);

        // Low address bits ignored
        axi_read(12'h006, data, resp);
        check("rd006_unaligned", 64'(data), 64'hDEADBEEF);

        // Byte strobes
        axi_write(12'h008, 32'h11223344, 4'hF, resp);
        axi_write(12'h008, 32'hAABBCCDD, 4'h5, resp);
        check("wr008_strb_bresp", 64'(resp), 64'd0);
        axi_read(12'h008, data, resp);
        check("rd008_strb", 64'(data), 64'h11BB33DD);

        // Zero strobe leaves register alone but still answers OKAY
        axi_write(12'h004, 32'hFFFFFFFF, 4'h0, resp);
        check("wr004_nostrb_bresp", 64'(resp), 64'd0);
        axi_read(12'h004, data, resp);
        check("rd004_nostrb", 64'(data), 64'hDEADBEEF);

        // Data arrives three cycles before the address
        WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK) check("wfirst_wready", 64'(WREADY), 64'd1);
        @(posedge ACLK); #1;
        WVALID = 1'b0; WDATA = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("wcapt_wready",  64'(WREADY),  64'd0);
            check("wcapt_awready", 64'(AWREADY), 64'd1);
            check("wcapt_arready", 64'(ARREADY), 64'd0);
            check("wcapt_bvalid",  64'(BVALID),  64'd0);
            @(posedge ACLK); #1;
        end
        AWADDR = 12'h00C; AWVALID = 1'b1; BREADY = 1'b1;
        @(negedge ACLK) check("wcapt_aw_accept", 64'(AWREADY), 64'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        bcount = 0; resp = 2'bxx;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            if (BVALID) begin bcount++; resp = BRESP; end
        end
        BREADY = 1'b0;
        $display("WR addr=00c data=cafef00d (data first) bvalid_count=%0d bresp=%b", bcount, resp);
        check("wcapt_single_bvalid", 64'(bcount), 64'd1);
        check("wcapt_bresp", 64'(resp), 64'd0);
        axi_read(12'h00C, data, resp);
        check("rd00c_wcapt", 64'(data), 64'hCAFEF00D);

        // Read and write arriving together: read first
        @(posedge ACLK); #1;
        ARADDR = 12'h004; ARVALID = 1'b1;
        AWADDR = 12'h010; WDATA = 32'h55667788; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        RREADY = 1'b0; BREADY = 1'b0;
        @(negedge ACLK);
        check("race_arready", 64'(ARREADY), 64'd1);
        check("race_awready", 64'(AWREADY), 64'd0);
        check("race_wready",  64'(WREADY),  64'd0);
        @(posedge ACLK); #1 ARVALID = 1'b0;
        @(negedge ACLK);
        check("race_rvalid",  64'(RVALID),  64'd1);
        check("race_rdata",   64'(RDATA),   64'hDEADBEEF);
        check("race_awready_in_rdata", 64'(AWREADY), 64'd0);
        RREADY = 1'b1;
        @(posedge ACLK); #1 RREADY = 1'b0;
        @(negedge ACLK);
        check("race_rvalid_done", 64'(RVALID), 64'd0);
        check("race_awready_after", 64'(AWREADY), 64'd1);
        @(posedge ACLK); #1 begin AWVALID = 1'b0; WVALID = 1'b0; end
        @(negedge ACLK);
        check("race_bvalid", 64'(BVALID), 64'd1);
        check("race_bresp",  64'(BRESP),  64'd0);
        BREADY = 1'b1;
        @(posedge ACLK); #1 BREADY = 1'b0;
        @(negedge ACLK) check("race_bvalid_done", 64'(BVALID), 64'd0);
        $display("RACE rd 004 then wr 010 data=55667788");
        axi_read(12'h010, data, resp);
        check("rd010_race", 64'(data), 64'h55667788);

        // Out-of-range accesses
        axi_read(12'h040, data, resp);
        check("rd040_rdata", 64'(data), 64'd0);
        check("rd040_rresp", 64'(resp), 64'(OOR_RESP));
        axi_write(12'h040, 32'h12345678, 4'hF, resp);
        check("wr040_bresp", 64'(resp), 64'(OOR_RESP));
        axi_read(12'h000, data, resp);
        check("rd000_untouched", 64'(data), 64'd0);

        // Read data held while RREADY is low, then reset mid-response
        @(posedge ACLK); #1;
        ARADDR = 12'h008; ARVALID = 1'b1; RREADY = 1'b0;
        @(posedge ACLK); #1 ARVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("hold_rvalid", 64'(RVALID), 64'd1);
            check("hold_rdata",  64'(RDATA),  64'h11BB33DD);
        end
        #2 ARESETN = 1'b0;
        #1;
        $display("RESET asserted during pending read response");
        check("midrst_rvalid",  64'(RVALID),  64'd0);
        check("midrst_rdata",   64'(RDATA),   64'd0);
        check("midrst_arready", 64'(ARREADY), 64'd0);
        @(posedge ACLK); #1;
        check("midrst_arready_held", 64'(ARREADY), 64'd0);
        @(negedge ACLK) ARESETN = 1'b1;
        @(posedge ACLK); #1;
        check("midrst_arready_back", 64'(ARREADY), 64'd1);
        check("midrst_rvalid_after", 64'(RVALID), 64'd0);
        axi_read(12'h004, data, resp);
        check("midrst_rd004", 64'(data), 64'd0);
        axi_read(12'h008, data, resp);
        check("midrst_rd008", 64'(data), 64'd0);
        axi_read(12'h00C, data, resp);
        check("midrst_rd00c", 64'(data), 64'd0);
        axi_read(12'h010, data, resp);
        check("midrst_rd010", 64'(data), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile_slave.md
AXI_LITE_REGFILE_SLAVE -- requirements
Module: axi_lite_regfile_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the byte-address width of AWADDR/ARADDR.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width; legal values are 32 and 64.
REQ-003 Parameter NUM_REGS, default 16, SHALL set the register count (1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8))).
REQ-004 Derived STRB_WIDTH SHALL equal DATA_WIDTH/8, and OFFS SHALL equal log2(STRB_WIDTH).
REQ-005 Ports SHALL be (name  direction  width  meaning):
  ACLK  in  1  single clock, all logic on rising edge
  ARESETN  in  1  asynchronous active-low reset
  AWADDR  in  ADDR_WIDTH  write address
  AWVALID/AWREADY  in/out  1  write-address handshake
  WDATA  in  DATA_WIDTH  write data
  WSTRB  in  STRB_WIDTH  byte strobes
  WVALID/WREADY  in/out  1  write-data handshake
  BRESP  out  2  write response
  BVALID/BREADY  out/in  1  write-response handshake
  ARADDR  in  ADDR_WIDTH  read address
  ARVALID/ARREADY  in/out  1  read-address handshake
  RDATA  out  DATA_WIDTH  read data
  RRESP  out  2  read response
  RVALID/RREADY  out/in  1  read-data handshake

Function
REQ-006 Register index SHALL be ADDR[ADDR_WIDTH-1:OFFS]; ADDR[OFFS-1:0] SHALL be ignored; index < NUM_REGS is in range.
REQ-007 The FSM SHALL have states IDLE, RDATA, WCAPT, WRESP; at most one transaction outstanding.
REQ-008 In IDLE, ARREADY SHALL be 1; AWREADY and WREADY SHALL be 1 only when ARVALID=0 (read wins simultaneous arrival).
REQ-009 IDLE + AR handshake -> RDATA next cycle; RDATA/RRESP registered at the handshake edge, RVALID=1.
REQ-010 In RDATA, RVALID, RDATA and RRESP SHALL hold stable until RREADY=1; then -> IDLE, RVALID=0.
REQ-011 IDLE + both AW and W handshakes in the same cycle -> write performed at that edge, -> WRESP.
REQ-012 IDLE + only one of AW/W handshakes -> WCAPT, captured half stored; ready of the captured channel SHALL be 0 in WCAPT.
REQ-013 In WCAPT, on the missing handshake, the write SHALL be performed at that edge, -> WRESP; ARREADY SHALL be 0 in WCAPT, RDATA and WRESP.
REQ-014 A write SHALL update only bytes whose WSTRB bit is 1; WSTRB=0 SHALL leave the register unchanged and still return OKAY.
REQ-015 In WRESP, BVALID=1 and BRESP SHALL hold until BREADY=1; then -> IDLE.
REQ-016 A read issued after a write response SHALL return the written value (no read-after-write hazard).
REQ-017 In-range accesses SHALL return RESP_OKAY (2'b00); EXOKAY SHALL never be returned.

Reset
REQ-018 ARESETN=0 SHALL asynchronously force state IDLE, all registers to 0, and ARREADY, AWREADY, WREADY, RVALID, BVALID, RDATA, RRESP, BRESP to 0.
REQ-019 Reset mid-transaction SHALL discard the transaction with no response; any half-captured write SHALL be lost.
REQ-020 Readies SHALL stay 0 while ARESETN=0 and SHALL follow REQ-008 from the first edge after deassertion.

Configuration
REQ-021 With macro AXI_LITE_ERR_RESP_EN defined, out-of-range reads SHALL return RDATA=0 with RESP_SLVERR (2'b10), and out-of-range writes SHALL modify nothing and return RESP_SLVERR.
REQ-022 Without AXI_LITE_ERR_RESP_EN, out-of-range reads SHALL return RDATA=0 with OKAY, and writes SHALL be silently dropped with OKAY.

Verification
REQ-023 Write 0xDEADBEEF to 0x004 with WSTRB=0xF, then read 0x004 -> BRESP=00, RDATA=0xDEADBEEF, RRESP=00.
REQ-024 Write 0x11223344 to 0x008, then write 0xAABBCCDD with WSTRB=0x5 -> read returns 0x11BB33DD.
REQ-025 W presented 3 cycles before AW at 0x00C -> WCAPT entered, single BVALID after AW, register written once.
REQ-026 ARVALID and AWVALID/WVALID asserted in the same cycle -> read completes first, write then completes with BRESP=00.
REQ-027 With AXI_LITE_ERR_RESP_EN, NUM_REGS=16, read 0x040 -> RRESP=10, RDATA=0; without it -> RRESP=00, RDATA=0.
REQ-028 ARESETN pulsed low while RVALID=1 with RREADY=0 -> RVALID=0 immediately, and all registers read 0 afterwards.
